clock24_ctrl: RTL and testbench

Mode/sequence controller for the 24-hour clock. Consumes the 1 Hz enable and 2 Hz blink signal from the one-second divider and maintains hour/minute/second time-of-day registers. Runs the user time-setting state machine and drives a restart pulse back to the divider. Sits between the divider and the 7-segment display formatter; button inputs arrive already debounced as single-cycle pulses.

---
 rtl/clock24_pkg.sv | 19 +
 rtl/clock24_modn.sv | 38 +++
 rtl/clock24_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clock24_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock24_pkg.sv
// clock24_pkg: shared state encoding, field limits and field widths for the
// 24-hour clock controller and its modulo-N field counters.
package clock24_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  localparam int HOUR_LAST = 23;
  localparam int MIN_LAST  = 59;
  localparam int SEC_LAST  = 59;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

endpackage

// File: rtl/clock24_modn.sv
// clock24_modn: modulo-(LAST+1) up/down counter for one time-of-day field.
//   i_clk, i_rst_n : clock, async active-low reset (loads INIT)
//   i_clr          : synchronous load of zero, beats inc/dec
//   i_inc, i_dec   : step up/down with wrap; both together is a no-op
//   o_val          : current value (registered)
//   o_cout         : combinational carry, high when this cycle's inc wraps
module clock24_modn #(
  parameter int W    = 6,
  parameter int LAST = 59,
  parameter int INIT = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_val,
  output logic         o_cout
);

  localparam logic [W-1:0] L_LAST = W'(LAST);
  localparam logic [W-1:0] L_INIT = W'(INIT);

  logic [W-1:0] r_val;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               r_val <= L_INIT;
    else if (i_clr)             r_val <= '0;
    else if (i_inc && !i_dec)   r_val <= (r_val == L_LAST) ? '0 : r_val + 1'b1;
    else if (i_dec && !i_inc)   r_val <= (r_val == '0) ? L_LAST : r_val - 1'b1;
  end

  // Carry is independent of i_clr so a tick that coincides with a clear
  // still propagates into the next field.
  assign o_cout = i_inc && !i_dec && (r_val == L_LAST);
  assign o_val  = r_val;

endmodule

// File: rtl/clock24_ctrl.sv
// clock24_ctrl: time-of-day registers plus the RUN / SET_HOUR / SET_MIN
// time-setting state machine for the 24-hour clock.
//   CLK, RST       : clock, async active-low reset
//   EN1HZ, SIG2HZ  : 1 Hz tick pulse and 2 Hz blink wave from the divider
//   MODE, UP, DOWN : debounced single-cycle button pulses
//   DIV_RST        : one-cycle restart request back to the divider
//   HOUR, MIN, SEC : binary time of day
//   BLANK_H/M      : blink blanking for the field being edited
//   DAY_TICK       : one-cycle pulse on midnight rollover
module clock24_ctrl
  import clock24_pkg::*;
#(
  parameter int INIT_HOUR   = 0,
  parameter int INIT_MIN    = 0,
  parameter int TIMEOUT_SEC = 30
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN1HZ,
  input  logic              SIG2HZ,
  input  logic              MODE,
  input  logic              UP,
  input  logic              DOWN,
  output logic              DIV_RST,
  output logic [HOUR_W-1:0] HOUR,
  output logic [MIN_W-1:0]  MIN,
  output logic [SEC_W-1:0]  SEC,
  output logic              BLANK_H,
  output logic              BLANK_M,
  output logic              DAY_TICK
);

  state_t r_state, w_state_nxt;
  logic   w_div_req;
  logic   r_div_rst, r_day_tick, r_blank_h, r_blank_m;

  logic w_in_run, w_in_hour, w_in_min;
  logic w_up_only, w_dn_only, w_btn;
  logic w_sec_cout, w_min_cout, w_hour_cout;
  logic w_to_expire;

  assign w_in_run  = (r_state == ST_RUN);
  assign w_in_hour = (r_state == ST_SET_HOUR);
  assign w_in_min  = (r_state == ST_SET_MIN);

  // MODE wins over UP/DOWN; UP with DOWN cancels out.
  assign w_up_only = UP   && !DOWN && !MODE;
  assign w_dn_only = DOWN && !UP   && !MODE;
  assign w_btn     = MODE || UP || DOWN;

  // Fields. Carries only chain in RUN so editing a field never spills over.
  clock24_modn #(.W(SEC_W), .LAST(SEC_LAST), .INIT(0)) u_sec (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_clr   (w_in_run && MODE),
    .i_inc   (w_in_run && EN1HZ),
    .i_dec   (1'b0),
    .o_val   (SEC),
    .o_cout  (w_sec_cout)
  );

  clock24_modn #(.W(MIN_W), .LAST(MIN_LAST), .INIT(INIT_MIN)) u_min (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_clr   (1'b0),
    .i_inc   ((w_in_run && w_sec_cout) || (w_in_min && w_up_only)),
    .i_dec   (w_in_min && w_dn_only),
    .o_val   (MIN),
    .o_cout  (w_min_cout)
  );

  clock24_modn #(.W(HOUR_W), .LAST(HOUR_LAST), .INIT(INIT_HOUR)) u_hour (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_clr   (1'b0),
    .i_inc   ((w_in_run && w_min_cout) || (w_in_hour && w_up_only)),
    .i_dec   (w_in_hour && w_dn_only),
    .o_val   (HOUR),
    .o_cout  (w_hour_cout)
  );

  // Inactivity timeout. The counter sits at zero in RUN, so entry into a set
  // state always starts from zero; any button clears it. Expiry fires on the
  // tick that would bring the count to TIMEOUT_SEC, and never alongside a
  // button (MODE therefore takes precedence).
  generate
    if (TIMEOUT_SEC > 0) begin : g_timeout
      localparam int TO_W = $clog2(TIMEOUT_SEC + 1);
      localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_SEC - 1);
      logic [TO_W-1:0] r_to_cnt;

      assign w_to_expire = !w_in_run && !w_btn && EN1HZ && (r_to_cnt == TO_LAST);

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                      r_to_cnt <= '0;
        else if (w_in_run || w_btn)    r_to_cnt <= '0;
        else if (w_to_expire)          r_to_cnt <= '0;
        else if (EN1HZ)                r_to_cnt <= r_to_cnt + 1'b1;
      end
    end else begin : g_no_timeout
      assign w_to_expire = 1'b0;
    end
  endgenerate

  // State machine
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_req   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (MODE) begin
          w_state_nxt = ST_SET_HOUR;
          w_div_req   = 1'b1;
        end
      end
      ST_SET_HOUR: begin
        if (MODE) begin
          w_state_nxt = ST_SET_MIN;
        end else if (w_to_expire) begin
          w_state_nxt = ST_RUN;
          w_div_req   = 1'b1;
        end
      end
      ST_SET_MIN: begin
        if (MODE || w_to_expire) begin
          w_state_nxt = ST_RUN;
          w_div_req   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Registered outputs. A restart request right after one already issued is
  // dropped: the divider is still being cleared, so the one-cycle shift is
  // harmless and DIV_RST stays a single-cycle pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_div_rst  <= 1'b0;
      r_day_tick <= 1'b0;
      r_blank_h  <= 1'b0;
      r_blank_m  <= 1'b0;
    end else begin
      r_div_rst  <= w_div_req && !r_div_rst;
      r_day_tick <= w_in_run && w_hour_cout;
      // Blanking follows the state being entered so it lines up with the
      // field values shown in the same cycle.
      r_blank_h  <= (w_state_nxt == ST_SET_HOUR) && SIG2HZ;
      r_blank_m  <= (w_state_nxt == ST_SET_MIN)  && SIG2HZ;
    end
  end

  assign DIV_RST  = r_div_rst;
  assign DAY_TICK = r_day_tick;
  assign BLANK_H  = r_blank_h;
  assign BLANK_M  = r_blank_m;

endmodule

// File: tb/tb_clock24_ctrl.sv
module tb_clock24_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic EN1HZ = 1'b0, SIG2HZ = 1'b1, MODE = 1'b0, UP = 1'b0, DOWN = 1'b0;

  // dut_a: INIT 12:34, timeout 30; dut_b: timeout 3; dut_c: timeout disabled
  logic       div_a, div_b, div_c, bh_a, bh_b, bh_c, bm_a, bm_b, bm_c, dt_a, dt_b, dt_c;
  logic [4:0] hour_a, hour_b, hour_c;
  logic [5:0] min_a, min_b, min_c, sec_a, sec_b, sec_c;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  clock24_ctrl #(.INIT_HOUR(12), .INIT_MIN(34), .TIMEOUT_SEC(30)) dut_a (
    .CLK(CLK), .RST(RST), .EN1HZ(EN1HZ), .SIG2HZ(SIG2HZ), .MODE(MODE), .UP(UP), .DOWN(DOWN),
    .DIV_RST(div_a), .HOUR(hour_a), .MIN(min_a), .SEC(sec_a),
    .BLANK_H(bh_a), .BLANK_M(bm_a), .DAY_TICK(dt_a));

  clock24_ctrl #(.INIT_HOUR(0), .INIT_MIN(0), .TIMEOUT_SEC(3)) dut_b (
    .CLK(CLK), .RST(RST), .EN1HZ(EN1HZ), .SIG2HZ(SIG2HZ), .MODE(MODE), .UP(UP), .DOWN(DOWN),
    .DIV_RST(div_b), .HOUR(hour_b), .MIN(min_b), .SEC(sec_b),
    .BLANK_H(bh_b), .BLANK_M(bm_b), .DAY_TICK(dt_b));

  clock24_ctrl #(.INIT_HOUR(0), .INIT_MIN(0), .TIMEOUT_SEC(0)) dut_c (
    .CLK(CLK), .RST(RST), .EN1HZ(EN1HZ), .SIG2HZ(SIG2HZ), .MODE(MODE), .UP(UP), .DOWN(DOWN),
    .DIV_RST(div_c), .HOUR(hour_c), .MIN(min_c), .SEC(sec_c),
    .BLANK_H(bh_c), .BLANK_M(bm_c), .DAY_TICK(dt_c));

  // One-cycle input event; on return (next negedge) outputs show its effect.
  task automatic step(input logic en, input logic m, input logic u, input logic d);
    @(negedge CLK);
    EN1HZ = en; MODE = m; UP = u; DOWN = d;
    @(negedge CLK);
    EN1HZ = 1'b0; MODE = 1'b0; UP = 1'b0; DOWN = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b0;
    #2;
    tests++;
    if ({hour_a, min_a, sec_a} !== {5'd12, 6'd34, 6'd0}) begin
      fails++; $display("FAIL reset_time got %0d:%0d:%0d want 12:34:0", hour_a, min_a, sec_a);
    end
    tests++;
    if ({div_a, bh_a, bm_a, dt_a} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags got %b want 0000", {div_a, bh_a, bm_a, dt_a});
    end
    tests++;
    if ({hour_b, min_b, sec_b} !== 17'd0) begin
      fails++; $display("FAIL reset_time_b got %0d:%0d:%0d want 0:0:0", hour_b, min_b, sec_b);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_run_count();
    int div_seen = 0;
    for (int i = 0; i < 60; i++) begin
      step(1, 0, 0, 0);
      if (div_a) div_seen++;
    end
    tests++;
    if ({hour_a, min_a, sec_a} !== {5'd12, 6'd35, 6'd0}) begin
      fails++; $display("FAIL run_60s got %0d:%0d:%0d want 12:35:0", hour_a, min_a, sec_a);
    end
    tests++;
    if (div_seen !== 0) begin
      fails++; $display("FAIL run_no_divrst got %0d pulses want 0", div_seen);
    end
  endtask

  task automatic test_day_rollover();
    do_reset();
    step(0, 1, 0, 0);                          // SET_HOUR
    for (int i = 0; i < 11; i++) step(0, 0, 1, 0);
    step(0, 1, 0, 0);                          // SET_MIN
    for (int i = 0; i < 25; i++) step(0, 0, 1, 0);
    step(0, 1, 0, 0);                          // RUN
    for (int i = 0; i < 58; i++) step(1, 0, 0, 0);
    tests++;
    if ({hour_a, min_a, sec_a} !== {5'd23, 6'd59, 6'd58}) begin
      fails++; $display("FAIL preload got %0d:%0d:%0d want 23:59:58", hour_a, min_a, sec_a);
    end
    step(1, 0, 0, 0);
    tests++;
    if ({hour_a, min_a, sec_a, dt_a} !== {5'd23, 6'd59, 6'd59, 1'b0}) begin
      fails++; $display("FAIL pre_midnight got %0d:%0d:%0d tick %b want 23:59:59 tick 0", hour_a, min_a, sec_a, dt_a);
    end
    step(1, 0, 0, 0);
    tests++;
    if ({hour_a, min_a, sec_a, dt_a} !== {5'd0, 6'd0, 6'd0, 1'b1}) begin
      fails++; $display("FAIL midnight got %0d:%0d:%0d tick %b want 0:0:0 tick 1", hour_a, min_a, sec_a, dt_a);
    end
    @(negedge CLK);
    tests++;
    if (dt_a !== 1'b0) begin
      fails++; $display("FAIL day_tick_width got %b want 0", dt_a);
    end
  endtask

  task automatic test_set_hour();
    for (int i = 0; i < 41; i++) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    tests++;
    if ({sec_a, div_a, bh_a, bm_a} !== {6'd0, 1'b1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL enter_hour got sec %0d div %b bh %b bm %b want 0 1 1 0", sec_a, div_a, bh_a, bm_a);
    end
    @(negedge CLK);
    tests++;
    if (div_a !== 1'b0) begin
      fails++; $display("FAIL divrst_width got %b want 0", div_a);
    end
    step(0, 0, 0, 1);
    tests++;
    if (hour_a !== 5'd23) begin
      fails++; $display("FAIL hour_wrap_down got %0d want 23", hour_a);
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    tests++;
    if ({hour_a, min_a, sec_a} !== {5'd23, 6'd0, 6'd0}) begin
      fails++; $display("FAIL frozen got %0d:%0d:%0d want 23:0:0", hour_a, min_a, sec_a);
    end
    SIG2HZ = 1'b0;
    @(negedge CLK);
    tests++;
    if ({bh_a, bm_a} !== 2'b00) begin
      fails++; $display("FAIL blink_low got bh %b bm %b want 0 0", bh_a, bm_a);
    end
    SIG2HZ = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_set_min();
    step(0, 1, 0, 0);
    tests++;
    if ({div_a, bh_a, bm_a} !== 3'b001) begin
      fails++; $display("FAIL enter_min got div %b bh %b bm %b want 0 0 1", div_a, bh_a, bm_a);
    end
    step(0, 0, 0, 1);
    tests++;
    if (min_a !== 6'd59) begin
      fails++; $display("FAIL min_wrap_down got %0d want 59", min_a);
    end
    step(0, 0, 1, 0);
    tests++;
    if ({hour_a, min_a} !== {5'd23, 6'd0}) begin
      fails++; $display("FAIL min_wrap_up got %0d:%0d want 23:0", hour_a, min_a);
    end
    step(0, 1, 0, 0);
    tests++;
    if ({div_a, bh_a, bm_a} !== 3'b100) begin
      fails++; $display("FAIL exit_min got div %b bh %b bm %b want 1 0 0", div_a, bh_a, bm_a);
    end
    @(negedge CLK);
    tests++;
    if (div_a !== 1'b0) begin
      fails++; $display("FAIL exit_divrst_width got %b want 0", div_a);
    end
    step(1, 0, 0, 0);
    tests++;
    if (sec_a !== 6'd1) begin
      fails++; $display("FAIL first_second got %0d want 1", sec_a);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    tests++;
    if ({bm_b, bm_c} !== 2'b11) begin
      fails++; $display("FAIL to_enter_min got bm_b %b bm_c %b want 1 1", bm_b, bm_c);
    end
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    tests++;
    if ({bm_b, div_b} !== 2'b10) begin
      fails++; $display("FAIL to_not_yet got bm %b div %b want 1 0", bm_b, div_b);
    end
    step(1, 0, 0, 0);
    tests++;
    if ({bm_b, div_b, min_b} !== {1'b0, 1'b1, 6'd1}) begin
      fails++; $display("FAIL to_expire got bm %b div %b min %0d want 0 1 1", bm_b, div_b, min_b);
    end
    for (int i = 0; i < 100; i++) step(1, 0, 0, 0);
    tests++;
    if ({bm_c, min_c, sec_c} !== {1'b1, 6'd1, 6'd0}) begin
      fails++; $display("FAIL to_disabled got bm %b min %0d sec %0d want 1 1 0", bm_c, min_c, sec_c);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 24; i++) step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int i = 0; i < 59; i++) step(1, 0, 0, 0);
    tests++;
    if ({hour_a, min_a, sec_a} !== {5'd12, 6'd10, 6'd59}) begin
      fails++; $display("FAIL sim_setup got %0d:%0d:%0d want 12:10:59", hour_a, min_a, sec_a);
    end
    step(1, 1, 0, 0);
    tests++;
    if ({min_a, sec_a, bh_a, div_a} !== {6'd11, 6'd0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL tick_mode got min %0d sec %0d bh %b div %b want 11 0 1 1", min_a, sec_a, bh_a, div_a);
    end
    step(0, 0, 1, 1);
    tests++;
    if (hour_a !== 5'd12) begin
      fails++; $display("FAIL up_down got %0d want 12", hour_a);
    end
    step(0, 1, 1, 0);
    tests++;
    if ({hour_a, bh_a, bm_a} !== {5'd12, 1'b0, 1'b1}) begin
      fails++; $display("FAIL mode_up got hour %0d bh %b bm %b want 12 0 1", hour_a, bh_a, bm_a);
    end
    step(0, 0, 1, 0);
    #2;
    RST = 1'b0;
    #1;
    tests++;
    if ({hour_a, min_a, sec_a, bm_a} !== {5'd12, 6'd34, 6'd0, 1'b0}) begin
      fails++; $display("FAIL reset_mid_set got %0d:%0d:%0d bm %b want 12:34:0 bm 0", hour_a, min_a, sec_a, bm_a);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_day_rollover();
    test_set_hour();
    test_set_min();
    test_timeout();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
